demux3_buf: RTL and testbench
=============================

# demux3_buf

Registered 1-to-3 demultiplexer with valid/ready handshake on the input and on each of three output channels; the write-side counterpart of the processor's 3-way operand mux. A single producer stream (WIDTH-bit word plus 2-bit select) is routed to one of three consumers. Each consumer has a one-entry holding slot, so a stalled consumer blocks only traffic addressed to it. Used in the datapath to distribute FIR/ALU results to one of three sinks.

## Interface
- WIDTH, 8, data word width
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- d  input  WIDTH  input data word
- s  input  2  destination select: 00→ch0, 01→ch1, 10→ch2, 11→illegal (drop)
- in_valid  input  1  producer has a word on d/s
- in_ready  output  1  word on d/s is accepted at this edge if in_valid
- y0, y1, y2  output  WIDTH  channel data, meaningful only while matching valid is high
- y0_valid, y1_valid, y2_valid  output  1  channel slot holds a word
- y0_ready, y1_ready, y2_ready  input  1  consumer takes the word at this edge
- drop_count  output  8  number of words accepted with s=11, saturating at 8'hFF
- drop_err  output  1  sticky: set on first s=11 acceptance

## Operation
- Accept condition: in_valid && in_ready at the rising edge.
- in_ready is combinational from s and the addressed slot: for s=k (k=0..2), in_ready = !yk_valid || yk_ready. For s=11, in_ready = 1.
- On accept with s=k: slot k loads d and sets yk_valid at the same edge. The other slots are unaffected.
- On accept with s=11: no slot is written. drop_count increments (saturates at 255) and drop_err is set.
- Slot k pop: at an edge with yk_valid && yk_ready, yk_valid clears unless a push to k occurs at the same edge.
- Simultaneous pop and push on slot k: the new word replaces the old one and yk_valid stays 1. Full throughput is 1 word/cycle per channel.
- Producer rule: while in_valid && !in_ready, d and s must be held stable. The block does not latch a pending request.
- Consumer rule: yk and yk_valid are stable until the pop. yk_ready may toggle freely.
- Per-slot state: EMPTY (valid=0) ↔ FULL (valid=1).
  - EMPTY→FULL on push.
  - FULL→EMPTY on pop without push.
  - FULL→FULL on push+pop (data replaced) or on idle.
- yk data register holds its last value after a pop; only valid qualifies it.
- drop_err clears only on reset.

## Timing
- Latency: a word accepted at edge n appears on yk with yk_valid=1 after edge n (one cycle).
- No combinational path from d to yk.
- Combinational paths: s to in_ready, and yk_ready to in_ready.
- Reset (asynchronous assert, synchronous deassert handled outside the block):
  - y0..y2 = 0, all yk_valid = 0, drop_count = 0, drop_err = 0.
  - in_ready = 1 for every s.
- Reset mid-operation: buffered words are discarded with no pop. After release, the block behaves as freshly reset.
- All three slots full with all ready low: in_ready = 0 for s=00/01/10 and in_ready = 1 for s=11.

## Structure
- Shared package demux3_pkg holds:
  - sel_t (2-bit enum): SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_CH2=2'b10, SEL_DROP=2'b11.
  - DROP_CNT_W = 8.
- Sub-module out_slot (parameter WIDTH), instantiated three times.
  - Ports: push, push_data, pop_ready, valid, data, can_accept.
  - Contains the one-entry register and the push/pop rules above.
- Top level contains only the select decode, in_ready mux, and the drop counter/flag.

## Test plan
- Reset: hold reset_n=0 with in_valid=1 and s=00 → all yk_valid=0, drop_count=0, drop_err=0, in_ready=1. After release, the first accept occurs at the first edge.
- Routing: with all ready=1, send d=8'hFF/s=00, d=8'h00/s=01, d=8'h0F/s=10 on consecutive cycles → y0=FF, y1=00, y2=0F, each valid exactly one cycle after its accept, no bubbles.
- Backpressure isolation: y1_ready=0, push 8'hA5 to ch1, then 8'h3C to ch1 → second word stalls (in_ready=0, y1 holds A5). Meanwhile 8'h77/s=00 is accepted and appears on y0. Raising y1_ready gives A5 then 3C in order.
- Push+pop same edge: ch2 full with 8'h11, y2_ready=1, push 8'h22/s=10 → accepted, y2_valid stays 1, y2=22 next cycle.
- Drop path: 3 words with s=11 → no yk_valid rises, drop_count=3, drop_err=1. Then 260 drops → drop_count=8'hFF and holds.
- Reset mid-operation: all slots full with ready=0, pulse reset_n low between edges → yk_valid clear immediately (asynchronous). drop_err and drop_count clear.

Source files
------------

// File: rtl/demux3_pkg.sv
// Shared types and constants for the 1-to-3 registered demultiplexer.
package demux3_pkg;

    typedef enum logic [1:0] {
        SEL_CH0  = 2'b00,
        SEL_CH1  = 2'b01,
        SEL_CH2  = 2'b10,
        SEL_DROP = 2'b11
    } sel_t;

    localparam int unsigned DROP_CNT_W = 8;

endpackage

// File: rtl/demux3_buf_out_slot.sv
// One-entry output holding slot with valid/ready pop and replace-on-push.
module out_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A push wins over a same-edge pop, so the slot stays full with the new word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (valid_q && pop_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid      = valid_q;
    assign data       = data_q;
    assign can_accept = !valid_q || pop_ready;

endmodule

// File: rtl/demux3_buf.sv
// Registered 1-to-3 demultiplexer: select decode, in_ready mux, and drop accounting.
module demux3_buf
    import demux3_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      d,
    input  logic [1:0]            s,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      y0,
    output logic [WIDTH-1:0]      y1,
    output logic [WIDTH-1:0]      y2,
    output logic                  y0_valid,
    output logic                  y1_valid,
    output logic                  y2_valid,
    input  logic                  y0_ready,
    input  logic                  y1_ready,
    input  logic                  y2_ready,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  drop_err
);

    sel_t                  sel;
    logic [2:0]            can_acc;
    logic [2:0]            push;
    logic                  accept;
    logic                  drop;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  drop_err_q, drop_err_d;

    assign sel    = sel_t'(s);
    assign accept = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b1;
        push     = '0;
        drop     = 1'b0;
        unique case (sel)
            SEL_CH0: begin
                in_ready = can_acc[0];
                push[0]  = accept;
            end
            SEL_CH1: begin
                in_ready = can_acc[1];
                push[1]  = accept;
            end
            SEL_CH2: begin
                in_ready = can_acc[2];
                push[2]  = accept;
            end
            SEL_DROP: begin
                in_ready = 1'b1;
                drop     = accept;
            end
            default: ;
        endcase
    end

    out_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push[0]),
        .push_data  (d),
        .pop_ready  (y0_ready),
        .valid      (y0_valid),
        .data       (y0),
        .can_accept (can_acc[0])
    );

    out_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push[1]),
        .push_data  (d),
        .pop_ready  (y1_ready),
        .valid      (y1_valid),
        .data       (y1),
        .can_accept (can_acc[1])
    );

    out_slot #(.WIDTH(WIDTH)) u_slot2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push[2]),
        .push_data  (d),
        .pop_ready  (y2_ready),
        .valid      (y2_valid),
        .data       (y2),
        .can_accept (can_acc[2])
    );

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        drop_err_d = drop_err_q;
        if (drop) begin
            drop_err_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
            drop_err_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign drop_count = drop_cnt_q;
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_demux3_buf.sv
// Self-checking bench for demux3_buf: slot/queue model checked every cycle plus directed literals.
`timescale 1ns/1ps
module tb_demux3_buf;

    logic       clk;
    logic       reset_n;
    logic [7:0] d;
    logic [1:0] s;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y0, y1, y2;
    logic       y0_valid, y1_valid, y2_valid;
    logic       y0_ready, y1_ready, y2_ready;
    logic [7:0] drop_count;
    logic       drop_err;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    demux3_buf #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d          (d),
        .s          (s),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y0_valid   (y0_valid),
        .y1_valid   (y1_valid),
        .y2_valid   (y2_valid),
        .y0_ready   (y0_ready),
        .y1_ready   (y1_ready),
        .y2_ready   (y2_ready),
        .drop_count (drop_count),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural model: per-channel occupancy + word, and a drop tally.
    logic       m_full [3];
    logic [7:0] m_word [3];
    int         m_drops;
    logic       m_err;

    function automatic logic rdy_of(input int k);
        case (k)
            0: return y0_ready;
            1: return y1_ready;
            default: return y2_ready;
        endcase
    endfunction

    function automatic logic model_in_ready();
        if (s == 2'b11) return 1'b1;
        return !m_full[int'(s)] || rdy_of(int'(s));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                m_full[k] <= 1'b0;
                m_word[k] <= 8'h00;
            end
            m_drops <= 0;
            m_err   <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (in_valid && model_in_ready() && int'(s) == k) begin
                    m_full[k] <= 1'b1;
                    m_word[k] <= d;
                end else if (m_full[k] && rdy_of(k)) begin
                    m_full[k] <= 1'b0;
                end
            end
            if (in_valid && s == 2'b11) begin
                m_drops <= (m_drops >= 255) ? 255 : m_drops + 1;
                m_err   <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        check("cmp_y0_valid", {31'd0, y0_valid}, {31'd0, m_full[0]});
        check("cmp_y1_valid", {31'd0, y1_valid}, {31'd0, m_full[1]});
        check("cmp_y2_valid", {31'd0, y2_valid}, {31'd0, m_full[2]});
        if (m_full[0]) check("cmp_y0", {24'd0, y0}, {24'd0, m_word[0]});
        if (m_full[1]) check("cmp_y1", {24'd0, y1}, {24'd0, m_word[1]});
        if (m_full[2]) check("cmp_y2", {24'd0, y2}, {24'd0, m_word[2]});
        check("cmp_in_ready", {31'd0, in_ready}, {31'd0, model_in_ready()});
        check("cmp_drop_count", {24'd0, drop_count}, m_drops);
        check("cmp_drop_err", {31'd0, drop_err}, {31'd0, m_err});
    end

    // Present a word and wait (bounded) for its accepting edge; returns 2ns after that edge.
    task automatic send(input logic [7:0] dv, input logic [1:0] sv);
        logic ok;
        ok = 1'b0;
        d = dv;
        s = sv;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #2;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        check("send_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        d = 8'h55;
        s = 2'b00;
        in_valid = 1'b1;
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        y2_ready = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        check("rst_y0_valid", {31'd0, y0_valid}, 32'd0);
        check("rst_y1_valid", {31'd0, y1_valid}, 32'd0);
        check("rst_y2_valid", {31'd0, y2_valid}, 32'd0);
        check("rst_y_data", {8'd0, y0, y1, y2}, 32'd0);
        check("rst_drop_count", {24'd0, drop_count}, 32'd0);
        check("rst_drop_err", {31'd0, drop_err}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            #1;
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        end
        s = 2'b00;
        reset_n = 1'b1;

        // First edge after release accepts the pending word.
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        check("first_accept_valid", {31'd0, y0_valid}, 32'd1);
        check("first_accept_y0", {24'd0, y0}, 32'h55);

        // Routing, back-to-back with all consumers ready.
        send(8'hFF, 2'b00);
        check("route_y0", {23'd0, y0_valid, y0}, 32'h1FF);
        send(8'h00, 2'b01);
        check("route_y1", {23'd0, y1_valid, y1}, 32'h100);
        check("route_y0_popped", {31'd0, y0_valid}, 32'd0);
        send(8'h0F, 2'b10);
        check("route_y2", {23'd0, y2_valid, y2}, 32'h10F);
        check("route_y1_popped", {31'd0, y1_valid}, 32'd0);

        // Backpressure on ch1 must not block ch0.
        y1_ready = 1'b0;
        send(8'hA5, 2'b01);
        check("bp_y1_a5", {23'd0, y1_valid, y1}, 32'h1A5);
        send(8'h77, 2'b00);
        check("bp_y0_77", {23'd0, y0_valid, y0}, 32'h177);
        d = 8'h3C;
        s = 2'b01;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold_a5", {23'd0, y1_valid, y1}, 32'h1A5);
        end
        #1;
        y1_ready = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        check("bp_y1_3c", {23'd0, y1_valid, y1}, 32'h13C);
        @(posedge clk);
        #2;
        check("bp_y1_drained", {31'd0, y1_valid}, 32'd0);

        // Push and pop on the same edge replace the word.
        y2_ready = 1'b0;
        send(8'h11, 2'b10);
        check("pp_y2_11", {23'd0, y2_valid, y2}, 32'h111);
        y2_ready = 1'b1;
        send(8'h22, 2'b10);
        check("pp_y2_22", {23'd0, y2_valid, y2}, 32'h122);
        @(posedge clk);
        #2;

        // Drop path and saturation.
        for (int i = 0; i < 3; i++) send(8'h99, 2'b11);
        check("drop3_count", {24'd0, drop_count}, 32'd3);
        check("drop3_err", {31'd0, drop_err}, 32'd1);
        check("drop3_no_valid", {29'd0, y0_valid, y1_valid, y2_valid}, 32'd0);
        for (int i = 0; i < 260; i++) send(8'h5A, 2'b11);
        check("drop_sat", {24'd0, drop_count}, 32'hFF);
        send(8'h5A, 2'b11);
        check("drop_sat_hold", {24'd0, drop_count}, 32'hFF);

        // Fill all slots with consumers stalled, then reset between edges.
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        y2_ready = 1'b0;
        send(8'h01, 2'b00);
        send(8'h02, 2'b01);
        send(8'h03, 2'b10);
        for (int k = 0; k < 4; k++) begin
            s = 2'(k);
            #1;
            check("full_in_ready", {31'd0, in_ready}, (k == 3) ? 32'd1 : 32'd0);
        end
        check("full_data", {8'd0, y0, y1, y2}, 32'h010203);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valids", {29'd0, y0_valid, y1_valid, y2_valid}, 32'd0);
        check("mid_rst_drop_count", {24'd0, drop_count}, 32'd0);
        check("mid_rst_drop_err", {31'd0, drop_err}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1'b1;
        s = 2'b00;

        send(8'hC3, 2'b01);
        check("post_rst_y1", {23'd0, y1_valid, y1}, 32'h1C3);
        repeat (2) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
